// File: rtl/data_sync_pkg.sv
// Shared definitions for the data synchronizer family: FSM state encodings,
// legal parameter ranges and a small constant helper.
package data_sync_pkg;

  // Transmit FSM states; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } sync_state_e;

  // Legal ranges for the hold / gap timing parameters.
  localparam int unsigned HOLD_CYCLES_MIN = 32'd1;
  localparam int unsigned HOLD_CYCLES_MAX = 32'd255;
  localparam int unsigned GAP_CYCLES_MIN  = 32'd1;
  localparam int unsigned GAP_CYCLES_MAX  = 32'd255;

  // Larger of two unsigned values, usable in constant expressions.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/data_sync_tx.sv
// Source-domain launcher for a qualified multi-bit synchronizer.
// A word is registered onto Unsync_bus together with a level qualifier
// (bus_enable) that stays high for HOLD_CYCLES and is then forced low for at
// least GAP_CYCLES+1 cycles, so a slower destination can reliably see every
// qualifier edge while the bus is held stable.
module data_sync_tx
  import data_sync_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  output logic                 busy
);

  // Reject illegal configurations at elaboration.
  if (BUS_WIDTH < 32'd1) begin : g_bad_bus_width
    $error("data_sync_tx: BUS_WIDTH must be at least 1");
  end
  if ((HOLD_CYCLES < HOLD_CYCLES_MIN) || (HOLD_CYCLES > HOLD_CYCLES_MAX)) begin : g_bad_hold
    $error("data_sync_tx: HOLD_CYCLES out of range 1..255");
  end
  if ((GAP_CYCLES < GAP_CYCLES_MIN) || (GAP_CYCLES > GAP_CYCLES_MAX)) begin : g_bad_gap
    $error("data_sync_tx: GAP_CYCLES out of range 1..255");
  end

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 32'd1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 32'd1);

  sync_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;

  // Next-state, counter, qualifier and data-hold decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // in_ready is implied by being in IDLE.
          data_d  = in_data;
          en_d    = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          en_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          en_d    = 1'b0;
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        // Unreachable encoding: recover quietly with the qualifier low.
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        en_d    = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      en_q    <= 1'b0;
      data_q  <= {BUS_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  // Handshake/status decode from the state register only; the bus and its
  // qualifier come straight from flops so the destination sees no glitches.
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_HOLD) || (state_q == ST_GAP);
  assign bus_enable = en_q;
  assign Unsync_bus = data_q;

endmodule
